commit_rob: RTL and testbench

// Parametrised in-order commit stage with a DEPTH-entry reorder buffer. Dispatch allocates a tag per instruction.
// NUM_FU execution units return results out of order by tag. The head entry retires once per cycle to the register

---
 rtl/commit_rob.sv | 241 ++++++++++++++++++++++++
 tb/tb_commit_rob.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_rob.sv
// commit_rob: in-order commit stage with a DEPTH-entry reorder buffer.
// Dispatch allocates the tail slot. NUM_FU writeback channels complete entries by tag,
// in any order. The head entry retires to the register file at most once per cycle.
// A redirect or an exception at the head steers the PC generator and flushes every
// younger entry.
// Optional: define COMMIT_ROB_PERF_EN to add the saturating perf_commit and perf_flush
// counters.

// One ROB slot. A clear has priority over allocation, and allocation has priority over
// writeback.
module commit_rob_entry #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alloc,
  input  logic            clr,
  input  logic            wb,
  input  logic [4:0]      a_rd,
  input  logic            a_we,
  input  logic [XLEN-1:0] a_pc,
  input  logic            a_exc,
  input  logic [4:0]      a_code,
  input  logic [XLEN-1:0] a_vec,
  input  logic [XLEN-1:0] w_result,
  input  logic            w_redirect,
  input  logic [XLEN-1:0] w_new_pc,
  output logic            valid,
  output logic            done,
  output logic            exc,
  output logic            we,
  output logic            redirect,
  output logic [4:0]      rd,
  output logic [4:0]      code,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] vec,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] new_pc
);
  // slot state: clear > allocate > writeback (writeback only lands on a live slot)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0; done <= 1'b0; exc <= 1'b0; we <= 1'b0; redirect <= 1'b0;
      rd <= '0; code <= '0; pc <= '0; vec <= '0; result <= '0; new_pc <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (alloc) begin
      // faulting ops carry nothing to execute: complete now, never write rd
      valid    <= 1'b1;
      done     <= a_exc;
      exc      <= a_exc;
      we       <= a_we & ~a_exc;
      rd       <= a_rd;
      pc       <= a_pc;
      code     <= a_code;
      vec      <= a_vec;
      result   <= '0;
      redirect <= 1'b0;
      new_pc   <= '0;
    end else if (wb && valid) begin
      done     <= 1'b1;
      result   <= w_result;
      redirect <= w_redirect;
      new_pc   <= w_new_pc;
    end
  end
endmodule

module commit_rob #(
  parameter int XLEN   = 32,
  parameter int NUM_FU = 3,
  parameter int DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          disp_valid,
  output logic                          disp_ready,
  output logic [$clog2(DEPTH)-1:0]      disp_tag,
  input  logic [4:0]                    disp_rd,
  input  logic                          disp_we,
  input  logic [XLEN-1:0]               disp_pc,
  input  logic                          disp_exc_valid,
  input  logic [4:0]                    disp_exc_code,
  input  logic [XLEN-1:0]               disp_trap_vec,
  input  logic [NUM_FU-1:0]             fu_valid,
  output logic [NUM_FU-1:0]             fu_ready,
  input  logic [NUM_FU*$clog2(DEPTH)-1:0] fu_tag,
  input  logic [NUM_FU*XLEN-1:0]        fu_result,
  input  logic [NUM_FU-1:0]             fu_redirect,
  input  logic [NUM_FU*XLEN-1:0]        fu_new_pc,
  output logic                          rf_valid,
  input  logic                          rf_ready,
  output logic [4:0]                    rf_rd,
  output logic [XLEN-1:0]               rf_wdata,
  output logic                          pcg_valid,
  input  logic                          pcg_ready,
  output logic [XLEN-1:0]               pcg_pc,
  output logic                          trap_valid,
  output logic [XLEN-1:0]               trap_pc,
  output logic [XLEN-1:0]               trap_cause,
  output logic                          flush,
  output logic [$clog2(DEPTH):0]        occupancy
`ifdef COMMIT_ROB_PERF_EN
  ,
  output logic [63:0]                   perf_commit,
  output logic [31:0]                   perf_flush
`endif
);
  localparam int TAG_W = $clog2(DEPTH);

  logic [TAG_W:0]   head, tail;
  logic [TAG_W-1:0] hidx;
  logic             flush_q, full, disp_fire;
  logic             h_live, retire, flush_ret;

  logic [DEPTH-1:0]           e_valid, e_done, e_exc, e_we, e_redir;
  logic [DEPTH-1:0][4:0]      e_rd, e_code;
  logic [DEPTH-1:0][XLEN-1:0] e_pc, e_vec, e_result, e_new_pc;
  logic [DEPTH-1:0]           e_alloc, e_clr, e_wb, w_redir;
  logic [DEPTH-1:0][XLEN-1:0] w_result, w_new_pc;

  assign hidx      = head[TAG_W-1:0];
  assign occupancy = tail - head;
  assign full      = (head[TAG_W-1:0] == tail[TAG_W-1:0]) && (head[TAG_W] != tail[TAG_W]);
  // registered state only: a slot freed by this cycle's commit opens up next cycle
  assign disp_ready = !full && !flush_q;
  assign disp_fire  = disp_valid && disp_ready;
  assign disp_tag   = tail[TAG_W-1:0];
  assign fu_ready   = '1;
  assign flush      = flush_q;

  // head commit decision, purely from registered entry state plus the two ready inputs
  always_comb begin
    h_live    = e_valid[hidx] && e_done[hidx];
    rf_valid  = 1'b0;
    pcg_valid = 1'b0;
    pcg_pc    = '0;
    retire    = 1'b0;
    flush_ret = 1'b0;
    if (h_live) begin
      if (e_exc[hidx]) begin
        pcg_valid = 1'b1;
        pcg_pc    = e_vec[hidx];
        retire    = pcg_ready;
      end else if (e_redir[hidx]) begin
        // RF and PC-gen must both accept in the same cycle so the pair stays atomic
        rf_valid  = e_we[hidx];
        pcg_valid = 1'b1;
        pcg_pc    = e_new_pc[hidx];
        retire    = pcg_ready && (rf_ready || !e_we[hidx]);
      end else begin
        rf_valid = e_we[hidx];
        retire   = rf_ready || !e_we[hidx];
      end
      flush_ret = retire && (e_exc[hidx] || e_redir[hidx]);
    end
  end

  assign rf_rd      = rf_valid ? e_rd[hidx] : '0;
  assign rf_wdata   = rf_valid ? e_result[hidx] : '0;
  assign trap_valid = retire && e_exc[hidx];
  assign trap_pc    = trap_valid ? e_pc[hidx] : '0;
  assign trap_cause = trap_valid ? {{(XLEN-5){1'b0}}, e_code[hidx]} : '0;

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    // route the FU result (if any) that targets this slot; results are dropped while flushing
    always_comb begin
      e_wb[e]     = 1'b0;
      w_result[e] = '0;
      w_redir[e]  = 1'b0;
      w_new_pc[e] = '0;
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i] && !flush_q && fu_tag[i*TAG_W +: TAG_W] == TAG_W'(e)) begin
          e_wb[e]     = 1'b1;
          w_result[e] = fu_result[i*XLEN +: XLEN];
          w_redir[e]  = fu_redirect[i];
          w_new_pc[e] = fu_new_pc[i*XLEN +: XLEN];
        end
      end
    end

    assign e_alloc[e] = disp_fire && (tail[TAG_W-1:0] == TAG_W'(e));
    assign e_clr[e]   = flush_ret || (retire && hidx == TAG_W'(e));

    commit_rob_entry #(.XLEN(XLEN)) u_ent (
      .clk(clk), .rst_n(rst_n),
      .alloc(e_alloc[e]), .clr(e_clr[e]), .wb(e_wb[e]),
      .a_rd(disp_rd), .a_we(disp_we), .a_pc(disp_pc), .a_exc(disp_exc_valid),
      .a_code(disp_exc_code), .a_vec(disp_trap_vec),
      .w_result(w_result[e]), .w_redirect(w_redir[e]), .w_new_pc(w_new_pc[e]),
      .valid(e_valid[e]), .done(e_done[e]), .exc(e_exc[e]), .we(e_we[e]),
      .redirect(e_redir[e]), .rd(e_rd[e]), .code(e_code[e]), .pc(e_pc[e]),
      .vec(e_vec[e]), .result(e_result[e]), .new_pc(e_new_pc[e])
    );
  end

  // pointers: a flush restarts both just past the retiring op (same-cycle dispatch is discarded)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      flush_q <= 1'b0;
    end else begin
      flush_q <= flush_ret;
      if (flush_ret) begin
        head <= head + (TAG_W+1)'(1);
        tail <= head + (TAG_W+1)'(1);
      end else begin
        if (retire)    head <= head + (TAG_W+1)'(1);
        if (disp_fire) tail <= tail + (TAG_W+1)'(1);
      end
    end
  end

`ifdef COMMIT_ROB_PERF_EN
  // saturating retirement and flush-event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_commit <= '0;
      perf_flush  <= '0;
    end else begin
      if (retire && perf_commit != '1)   perf_commit <= perf_commit + 64'd1;
      if (flush_ret && perf_flush != '1) perf_flush  <= perf_flush + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  logic dup_tag;
  // two FUs completing the same tag in one cycle is a protocol error upstream
  always_comb begin
    dup_tag = 1'b0;
    for (int i = 0; i < NUM_FU; i++)
      for (int j = i + 1; j < NUM_FU; j++)
        if (fu_valid[i] && fu_valid[j] && fu_tag[i*TAG_W +: TAG_W] == fu_tag[j*TAG_W +: TAG_W])
          dup_tag = 1'b1;
  end
  a_dup_tag: assert property (@(posedge clk) disable iff (!rst_n) !dup_tag);
`endif
endmodule

// File: tb/tb_commit_rob.sv
// tb_commit_rob: directed scenarios followed by random traffic. Every cycle the DUT is
// compared with a queue-based reference model of the reorder buffer.
module tb_commit_rob;
  localparam int XLEN = 32, NUM_FU = 3, DEPTH = 8, TAG_W = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                      disp_valid, disp_ready, disp_we, disp_exc_valid;
  logic [TAG_W-1:0]          disp_tag;
  logic [4:0]                disp_rd, disp_exc_code;
  logic [XLEN-1:0]           disp_pc, disp_trap_vec;
  logic [NUM_FU-1:0]         fu_valid, fu_ready, fu_redirect;
  logic [NUM_FU*TAG_W-1:0]   fu_tag;
  logic [NUM_FU*XLEN-1:0]    fu_result, fu_new_pc;
  logic                      rf_valid, rf_ready, pcg_valid, pcg_ready, trap_valid, flush;
  logic [4:0]                rf_rd;
  logic [XLEN-1:0]           rf_wdata, pcg_pc, trap_pc, trap_cause;
  logic [TAG_W:0]            occupancy;
`ifdef COMMIT_ROB_PERF_EN
  logic [63:0]               perf_commit;
  logic [31:0]               perf_flush;
`endif

  commit_rob #(.XLEN(XLEN), .NUM_FU(NUM_FU), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_tag(disp_tag),
    .disp_rd(disp_rd), .disp_we(disp_we), .disp_pc(disp_pc),
    .disp_exc_valid(disp_exc_valid), .disp_exc_code(disp_exc_code), .disp_trap_vec(disp_trap_vec),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_tag(fu_tag), .fu_result(fu_result),
    .fu_redirect(fu_redirect), .fu_new_pc(fu_new_pc),
    .rf_valid(rf_valid), .rf_ready(rf_ready), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .pcg_valid(pcg_valid), .pcg_ready(pcg_ready), .pcg_pc(pcg_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .flush(flush), .occupancy(occupancy)
`ifdef COMMIT_ROB_PERF_EN
    , .perf_commit(perf_commit), .perf_flush(perf_flush)
`endif
  );

  int checks = 0, errors = 0;

  // reference model: program-order queue of live ops
  typedef struct {
    int tag; logic [4:0] rd; bit we; logic [31:0] pc; bit exc; logic [4:0] code;
    logic [31:0] vec; bit done; logic [31:0] result; bit redir; logic [31:0] npc;
  } ent_t;
  ent_t rob[$];
  int head_tag = 0, tail_tag = 0;
  bit fq = 0;
  logic [36:0] rf_log[$];   // observed RF writes {rd, data}

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    disp_valid = 0; disp_we = 0; disp_rd = 0; disp_pc = 0;
    disp_exc_valid = 0; disp_exc_code = 0; disp_trap_vec = 0;
    fu_valid = 0; fu_tag = 0; fu_result = 0; fu_redirect = 0; fu_new_pc = 0;
    rf_ready = 1; pcg_ready = 1;
  endtask

  task automatic disp(input logic [4:0] rd, input logic [31:0] pc, input bit we,
                      input bit exc, input logic [4:0] code, input logic [31:0] vec);
    disp_valid = 1; disp_rd = rd; disp_pc = pc; disp_we = we;
    disp_exc_valid = exc; disp_exc_code = code; disp_trap_vec = vec;
  endtask

  task automatic wb(input int i, input int t, input logic [31:0] res, input bit redir,
                    input logic [31:0] npc);
    fu_valid[i] = 1'b1;
    fu_tag[i*TAG_W +: TAG_W] = TAG_W'(t);
    fu_result[i*XLEN +: XLEN] = res;
    fu_redirect[i] = redir;
    fu_new_pc[i*XLEN +: XLEN] = npc;
  endtask

  // one clock: compare outputs with the model, advance the model, cross the edge
  task automatic cyc();
    bit rv, pv, tv, ret, fl, dr;
    logic [31:0] ppc;
    ent_t h, e;
    #1;
    rv = 0; pv = 0; tv = 0; ret = 0; fl = 0; ppc = 0;
    dr = (rob.size() < DEPTH) && !fq;
    if (rob.size() > 0 && rob[0].done) begin
      h = rob[0];
      if (h.exc) begin
        pv = 1; ppc = h.vec; ret = pcg_ready; tv = ret; fl = ret;
      end else if (h.redir) begin
        rv = h.we; pv = 1; ppc = h.npc; ret = pcg_ready && (rf_ready || !h.we); fl = ret;
      end else begin
        rv = h.we; ret = rf_ready || !h.we;
      end
    end
    chk("occupancy", 64'(occupancy), 64'(rob.size()));
    chk("disp_ready", 64'(disp_ready), 64'(dr));
    if (dr) chk("disp_tag", 64'(disp_tag), 64'(tail_tag));
    chk("flush", 64'(flush), 64'(fq));
    chk("rf_valid", 64'(rf_valid), 64'(rv));
    if (rv) begin
      chk("rf_rd", 64'(rf_rd), 64'(h.rd));
      chk("rf_wdata", 64'(rf_wdata), 64'(h.result));
    end
    chk("pcg_valid", 64'(pcg_valid), 64'(pv));
    if (pv) chk("pcg_pc", 64'(pcg_pc), 64'(ppc));
    chk("trap_valid", 64'(trap_valid), 64'(tv));
    if (tv) begin
      chk("trap_pc", 64'(trap_pc), 64'(h.pc));
      chk("trap_cause", 64'(trap_cause), 64'(h.code));
    end
    if (rf_valid === 1'b1 && rf_ready && (!pcg_valid || pcg_ready)) rf_log.push_back({rf_rd, rf_wdata});
    // writebacks land only on live entries and never during the flush cycle
    for (int i = 0; i < NUM_FU; i++)
      if (fu_valid[i] && !fq)
        for (int k = 0; k < rob.size(); k++)
          if (rob[k].tag == int'(fu_tag[i*TAG_W +: TAG_W])) begin
            e = rob[k]; e.done = 1; e.result = fu_result[i*XLEN +: XLEN];
            e.redir = fu_redirect[i]; e.npc = fu_new_pc[i*XLEN +: XLEN]; rob[k] = e;
          end
    if (ret) begin
      if (fl) begin
        rob.delete(); head_tag = (h.tag + 1) % DEPTH; tail_tag = head_tag;
      end else begin
        void'(rob.pop_front()); head_tag = (head_tag + 1) % DEPTH;
      end
    end
    if (!fl && disp_valid && dr) begin
      e.tag = tail_tag; e.rd = disp_rd; e.we = disp_we && !disp_exc_valid; e.pc = disp_pc;
      e.exc = disp_exc_valid; e.code = disp_exc_code; e.vec = disp_trap_vec;
      e.done = disp_exc_valid; e.result = 0; e.redir = 0; e.npc = 0;
      rob.push_back(e);
      tail_tag = (tail_tag + 1) % DEPTH;
    end
    fq = fl;
    @(posedge clk); #1;
  endtask

  // retire everything left, completing pending ops one per cycle
  task automatic drain();
    int n = 0;
    while ((rob.size() > 0 || fq) && n < 64) begin
      idle();
      foreach (rob[k]) if (!rob[k].done) begin wb(0, rob[k].tag, $urandom, 0, 0); break; end
      cyc(); n++;
    end
    chk("drain_timeout", 64'(rob.size()), 64'd0);
  endtask

  initial begin
    int ta, n0, bad;
    bit [DEPTH-1:0] used;
    idle();
    // reset state
    #3;
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("rst_fu_ready", 64'(fu_ready), 64'h7);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_outs", 64'({rf_valid, pcg_valid, trap_valid, flush, disp_tag}), 64'd0);
    chk("rst_data", 64'({rf_rd, rf_wdata, pcg_pc}), 64'd0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // single op, result next cycle, committed the cycle after
    idle(); disp(5, 32'h100, 1, 0, 0, 0); cyc();
    idle(); wb(0, 0, 32'hDEAD, 0, 0); cyc();
    idle(); #1;
    chk("t1_rf_valid", 64'(rf_valid), 64'd1);
    chk("t1_rf_rd", 64'(rf_rd), 64'd5);
    chk("t1_rf_wdata", 64'(rf_wdata), 64'hDEAD);
    cyc();

    // out-of-order completion, in-order RF writes
    ta = tail_tag; n0 = rf_log.size();
    for (int k = 0; k < 3; k++) begin idle(); disp(5'(11 + k), 32'h200 + 32'(4*k), 1, 0, 0, 0); cyc(); end
    idle(); wb(0, (ta + 2) % DEPTH, 32'hB3, 0, 0); cyc();
    idle(); wb(1, ta, 32'hB1, 0, 0); cyc();
    idle(); wb(2, (ta + 1) % DEPTH, 32'hB2, 0, 0); cyc();
    for (int k = 0; k < 4; k++) begin idle(); cyc(); end
    chk("t2_count", 64'(rf_log.size() - n0), 64'd3);
    chk("t2_w0", 64'(rf_log[n0]),     64'({5'd11, 32'hB1}));
    chk("t2_w1", 64'(rf_log[n0 + 1]), 64'({5'd12, 32'hB2}));
    chk("t2_w2", 64'(rf_log[n0 + 2]), 64'({5'd13, 32'hB3}));

    // fill, commit one, tail wrap
    ta = tail_tag;
    for (int k = 0; k < DEPTH; k++) begin idle(); rf_ready = 0; disp(5'(k + 1), 32'(k), 1, 0, 0, 0); cyc(); end
    idle(); rf_ready = 0; #1;
    chk("t3_full_occ", 64'(occupancy), 64'd8);
    chk("t3_full_ready", 64'(disp_ready), 64'd0);
    for (int k = 0; k < DEPTH; k++) begin
      if (k % 3 == 0) begin idle(); rf_ready = 0; end
      wb(k % 3, (ta + k) % DEPTH, 32'h3000 + 32'(k), 0, 0);
      if (k % 3 == 2 || k == DEPTH - 1) cyc();
    end
    idle(); cyc();   // one commit; disp_ready stays low this cycle
    idle(); rf_ready = 0; #1;
    chk("t3_ready_after", 64'(disp_ready), 64'd1);
    chk("t3_occ_after", 64'(occupancy), 64'd7);
    chk("t3_wrap_tag", 64'(disp_tag), 64'(ta));
    cyc();
    drain();

    // redirect flushes younger ops; late results dropped
    ta = tail_tag; n0 = rf_log.size();
    for (int k = 0; k < 4; k++) begin idle(); disp(5'(21 + k), 32'h400 + 32'(4*k), 1, 0, 0, 0); cyc(); end
    idle(); wb(0, ta, 32'hA1, 0, 0); wb(1, (ta + 1) % DEPTH, 32'hB1, 1, 32'h200); cyc();
    idle(); cyc();
    idle(); #1;
    chk("t4_pcg_valid", 64'(pcg_valid), 64'd1);
    chk("t4_pcg_pc", 64'(pcg_pc), 64'h200);
    chk("t4_rf_rd", 64'(rf_rd), 64'd22);
    cyc();
    idle(); wb(2, (ta + 2) % DEPTH, 32'hC1, 0, 0); #1;
    chk("t4_flush", 64'(flush), 64'd1);
    chk("t4_occ", 64'(occupancy), 64'd0);
    cyc();
    idle(); wb(0, (ta + 2) % DEPTH, 32'hC2, 0, 0); wb(1, (ta + 3) % DEPTH, 32'hD1, 0, 0); #1;
    chk("t4_flush_off", 64'(flush), 64'd0);
    cyc();
    for (int k = 0; k < 3; k++) begin idle(); cyc(); end
    bad = 0;
    for (int k = n0; k < rf_log.size(); k++) if (rf_log[k][36:32] == 5'd23 || rf_log[k][36:32] == 5'd24) bad++;
    chk("t4_no_young_writes", 64'(bad), 64'd0);
    chk("t4_writes", 64'(rf_log.size() - n0), 64'd2);

    // exception commit
    idle(); disp(7, 32'h40, 1, 1, 5'd2, 32'h800); cyc();
    idle(); #1;
    chk("t5_rf_valid", 64'(rf_valid), 64'd0);
    chk("t5_pcg_pc", 64'(pcg_pc), 64'h800);
    chk("t5_trap_valid", 64'(trap_valid), 64'd1);
    chk("t5_trap_cause", 64'(trap_cause), 64'd2);
    chk("t5_trap_pc", 64'(trap_pc), 64'h40);
    cyc();
    idle(); cyc();

    // redirect stalled on pcg_ready
    ta = tail_tag;
    idle(); disp(9, 32'h500, 1, 0, 0, 0); cyc();
    idle(); wb(1, ta, 32'h99, 1, 32'h300); cyc();
    for (int k = 0; k < 3; k++) begin
      idle(); pcg_ready = 0; #1;
      chk("t6_hold_pcg", 64'({pcg_valid, pcg_pc}), 64'({1'b1, 32'h300}));
      chk("t6_hold_rf", 64'({rf_valid, rf_wdata}), 64'({1'b1, 32'h99}));
      chk("t6_hold_occ", 64'(occupancy), 64'd1);
      cyc();
    end
    idle(); cyc();
    idle(); #1;
    chk("t6_flush", 64'(flush), 64'd1);
    cyc();

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      idle();
      rf_ready = ($urandom % 4) != 0;
      pcg_ready = ($urandom % 3) != 0;
      if ($urandom % 3 != 0)
        disp(5'($urandom), $urandom, ($urandom % 4) != 0, ($urandom % 16) == 0, 5'($urandom), $urandom);
      used = '0;
      for (int i = 0; i < NUM_FU; i++) begin
        int t;
        t = -1;
        if ($urandom % 2 == 0) begin
          if ($urandom % 8 == 0) t = int'($urandom % DEPTH);
          else if (rob.size() > 0) begin
            int k;
            k = int'($urandom % rob.size());
            if (!rob[k].done) t = rob[k].tag;
          end
          if (t >= 0 && !used[t]) begin
            used[t] = 1'b1;
            wb(i, t, $urandom, ($urandom % 10) == 0, $urandom);
          end
        end
      end
      cyc();
    end
    drain();

    // reset in the middle of a stalled commit
    idle(); disp(3, 32'h10, 1, 0, 0, 0); cyc();
    idle(); rf_ready = 0; disp(4, 32'h14, 1, 0, 0, 0); wb(0, (tail_tag + DEPTH - 1) % DEPTH, 32'h77, 0, 0); cyc();
    idle(); rf_ready = 0; #2;
    chk("mid_pre_rf_valid", 64'(rf_valid), 64'd1);
    rst_n = 0; #1;
    chk("mid_rst_occ", 64'(occupancy), 64'd0);
    chk("mid_rst_rf_valid", 64'(rf_valid), 64'd0);
    chk("mid_rst_ready", 64'(disp_ready), 64'd1);
    rob.delete(); head_tag = 0; tail_tag = 0; fq = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    idle(); disp(6, 32'h20, 1, 0, 0, 0); cyc();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
